vga_sync_gen: RTL and testbench

VGA raster timing generator for the PixelStream video path. It produces horizontal and vertical sync, the active-video flag and the current scan coordinates, one pixel per enabled clock. It sits directly upstream of the VGA stream join stage, which packs HSync, VSync, ActiveVideo, XCoord and YCoord into the 23-bit VGA stream. Defaults give 640x480 at 60 Hz with a 25 MHz pixel rate.

---
 rtl/vga_sync_gen.sv | 85 ++++++++
 tb/tb_vga_sync_gen.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster timing generator (sync, active flag, scan coordinates)
// Optional FrameStart output is enabled by defining PXS_VGA_FRAME_START_EN.
module vga_sync_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       hsync,
  output logic       vsync,
  output logic [9:0] xcoord,
  output logic [9:0] ycoord,
  output logic       active_video
`ifdef PXS_VGA_FRAME_START_EN
  ,
  output logic       frame_start
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 11-bit decode bounds so a window edge of exactly 1024 still compares correctly
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_cfg_check
    $error("vga_sync_gen: H_TOTAL=%0d / V_TOTAL=%0d exceed the 10-bit counters", H_TOTAL, V_TOTAL);
  end

  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic [10:0] hpos;
  logic [10:0] vpos;

  assign hpos = {1'b0, hcnt};
  assign vpos = {1'b0, vcnt};

  // Outputs decode the pre-increment counters so every output describes the same pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt         <= '0;
      vcnt         <= '0;
      xcoord       <= '0;
      ycoord       <= '0;
      active_video <= 1'b0;
      hsync        <= ~HS_POL;
      vsync        <= ~VS_POL;
`ifdef PXS_VGA_FRAME_START_EN
      frame_start  <= 1'b0;
`endif
    end else if (enable) begin
      xcoord       <= hcnt;
      ycoord       <= vcnt;
      active_video <= (hpos < H_ACT_END) && (vpos < V_ACT_END);
      hsync        <= (hpos >= H_SYNC_BEG && hpos < H_SYNC_END) ? HS_POL : ~HS_POL;
      vsync        <= (vpos >= V_SYNC_BEG && vpos < V_SYNC_END) ? VS_POL : ~VS_POL;
`ifdef PXS_VGA_FRAME_START_EN
      frame_start  <= (hcnt == 10'd0) && (vcnt == 10'd0);
`endif
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench: default-timing and small-timing instances vs arithmetic raster model
// Optional FrameStart checks are compiled in when PXS_VGA_FRAME_START_EN is defined.
module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;

  logic       hs0, vs0, act0, hs1, vs1, act1;
  logic [9:0] x0, y0, x1, y1;
`ifdef PXS_VGA_FRAME_START_EN
  logic       fs0, fs1;
`endif

  int total = 0;
  int bad = 0;
  int cnt = 0;      // enabled edges since the last reset
  bit run = 1'b0;

  always #5 clk = ~clk;

  vga_sync_gen u_def (
    .clk(clk), .rst(rst), .enable(enable),
    .hsync(hs0), .vsync(vs0), .xcoord(x0), .ycoord(y0), .active_video(act0)
`ifdef PXS_VGA_FRAME_START_EN
    , .frame_start(fs0)
`endif
  );

  // small raster: 24 x 17, positive sync polarities
  vga_sync_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_small (
    .clk(clk), .rst(rst), .enable(enable),
    .hsync(hs1), .vsync(vs1), .xcoord(x1), .ycoord(y1), .active_video(act1)
`ifdef PXS_VGA_FRAME_START_EN
    , .frame_start(fs1)
`endif
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s cnt=%0d got=%0d expected=%0d", name, cnt, got, exp);
    end
  endtask

  // Expected outputs after n enabled edges since reset (n=0 means reset values)
  function automatic void model(input int n, input int ha, input int hf, input int hw, input int hb,
                                input int va, input int vf, input int vw, input int vb,
                                input bit hp, input bit vp,
                                output int x, output int y, output bit act,
                                output bit hs, output bit vs, output bit fs);
    int p;
    if (n == 0) begin
      x = 0; y = 0; act = 0; hs = ~hp; vs = ~vp; fs = 0;
    end else begin
      p   = n - 1;
      x   = p % (ha + hf + hw + hb);
      y   = (p / (ha + hf + hw + hb)) % (va + vf + vw + vb);
      act = (x < ha) && (y < va);
      hs  = (x >= ha + hf && x < ha + hf + hw) ? hp : ~hp;
      vs  = (y >= va + vf && y < va + vf + vw) ? vp : ~vp;
      fs  = (x == 0) && (y == 0);
    end
  endfunction

  always @(negedge clk) begin
    int ex, ey;
    bit ea, eh, ev, ef;
    if (run) begin
      model(cnt, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, ex, ey, ea, eh, ev, ef);
      chk("def_x", x0, ex);
      chk("def_y", y0, ey);
      chk("def_active", act0, ea);
      chk("def_hsync", hs0, eh);
      chk("def_vsync", vs0, ev);
`ifdef PXS_VGA_FRAME_START_EN
      chk("def_frame_start", fs0, ef);
`endif
      model(cnt, 16, 2, 3, 3, 10, 2, 2, 3, 1'b1, 1'b1, ex, ey, ea, eh, ev, ef);
      chk("small_x", x1, ex);
      chk("small_y", y1, ey);
      chk("small_active", act1, ea);
      chk("small_hsync", hs1, eh);
      chk("small_vsync", vs1, ev);
`ifdef PXS_VGA_FRAME_START_EN
      chk("small_frame_start", fs1, ef);
`endif
    end
  end

  task automatic tick(input bit en);
    enable = en;
    @(posedge clk);
    if (en && !rst) cnt++;
    #1;
  endtask

  initial begin
    run = 1'b1;
    repeat (3) tick(1'b1);
    chk("reset_x", x0, 0);
    chk("reset_active", act0, 0);
    chk("reset_hsync", hs0, 1);
    chk("reset_vsync", vs0, 1);
    rst = 1'b0;

    tick(1'b1);
    chk("first_x", x0, 0);
    chk("first_y", y0, 0);
    chk("first_active", act0, 1);
    chk("first_hsync", hs0, 1);
    chk("first_vsync", vs0, 1);

    for (int i = 1; i <= 800; i++) begin
      tick(1'b1);
      if (i == 639) chk("lit_last_active", act0, 1);
      if (i == 640) chk("lit_first_blank", act0, 0);
      if (i == 655) chk("lit_hsync_pre", hs0, 1);
      if (i == 656) begin chk("lit_hsync_x", x0, 656); chk("lit_hsync_on", hs0, 0); end
      if (i == 751) chk("lit_hsync_last", hs0, 0);
      if (i == 752) chk("lit_hsync_off", hs0, 1);
      if (i == 287) chk("lit_small_vs_pre", vs1, 0);
      if (i == 288) begin chk("lit_small_vs_y", y1, 12); chk("lit_small_vs_on", vs1, 1); end
      if (i == 408) begin chk("lit_small_wrap_x", x1, 0); chk("lit_small_wrap_y", y1, 0); end
      if (i == 800) begin chk("lit_line1_x", x0, 0); chk("lit_line1_y", y0, 1); end
    end

    for (int i = 0; i < 3000; i++) tick(1'(($urandom & 32'h1)));

    // asynchronous mid-frame reset, held for three cycles
    rst = 1'b1;
    #1;
    cnt = 0;
    chk("async_reset_x", x0, 0);
    chk("async_reset_y", y0, 0);
    chk("async_reset_active", act0, 0);
    chk("async_reset_small_hsync", hs1, 0);
    repeat (3) tick(1'(($urandom & 32'h1)));
    rst = 1'b0;
    tick(1'b0);
    tick(1'b1);
    chk("restart_x", x0, 0);
    chk("restart_y", y0, 0);
    chk("restart_active", act0, 1);

    for (int i = 0; i < 2000; i++) tick(1'(($urandom & 32'h1)));

    @(posedge clk);
    #1;
    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
